// File: rtl/carregador_programa.sv
// Program loader: packs a little-endian byte stream into 32-bit words written to instruction memory, holding the core in reset until done.
// Optional trailer-byte XOR checksum when CARREGADOR_CHECKSUM_EN is defined.
module carregador_programa #(
    parameter int NUM_MAX = 32,
    parameter int ENDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inicio,
    input  logic [5:0]        qtd_palavras,
    input  logic [7:0]        byte_in,
    input  logic              byte_valido,
    output logic              pronto,
    output logic              instr_we,
    output logic [ENDR_W-1:0] instr_endr,
    output logic [31:0]       instr_dado,
    output logic              carregando,
    output logic              concluido,
    output logic              cpu_reset,
    output logic              erro
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        RECEBE    = 3'd1,
        ESCREVE   = 3'd2,
`ifdef CARREGADOR_CHECKSUM_EN
        CHECA     = 3'd3,
`endif
        CONCLUIDO = 3'd4
    } estado_t;

`ifdef CARREGADOR_CHECKSUM_EN
    localparam estado_t FIM_CARGA = CHECA;
`else
    localparam estado_t FIM_CARGA = CONCLUIDO;
`endif
    localparam logic [5:0] NUM_MAX_C = 6'(NUM_MAX);

    estado_t           estado_q, estado_d;
    logic [5:0]        cont_q, cont_d;
    logic [ENDR_W:0]   endr_q, endr_d;     // one extra bit: holds NUM_MAX after a full load
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       dado_q, dado_d;
    logic              carregando_q, carregando_d;
    logic              concluido_q, concluido_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              aceita;
    logic              ocioso_ou_fim;
    logic [5:0]        qtd_sat;

    assign ocioso_ou_fim = (estado_q == OCIOSO) || (estado_q == CONCLUIDO);
    assign qtd_sat       = (qtd_palavras > NUM_MAX_C) ? NUM_MAX_C : qtd_palavras;
    assign aceita        = byte_valido && pronto;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado_q <= OCIOSO;
        else       estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO, CONCLUIDO:
                if (inicio) estado_d = (qtd_sat == 6'd0) ? FIM_CARGA : RECEBE;
            RECEBE:
                if (aceita && idx_q == 2'd3) estado_d = ESCREVE;
            ESCREVE:
                estado_d = (cont_q == 6'd1) ? FIM_CARGA : RECEBE;
`ifdef CARREGADOR_CHECKSUM_EN
            CHECA:
                if (aceita) estado_d = CONCLUIDO;
`endif
            default: estado_d = OCIOSO;
        endcase
    end

    always_comb begin
`ifdef CARREGADOR_CHECKSUM_EN
        pronto = (estado_q == RECEBE) || (estado_q == CHECA);
`else
        pronto = (estado_q == RECEBE);
`endif
        instr_we     = (estado_q == ESCREVE);
        concluido_d  = (estado_d == CONCLUIDO);
        cpu_reset_d  = !concluido_d;
        carregando_d = (estado_d != OCIOSO) && (estado_d != CONCLUIDO);
    end

`ifdef CARREGADOR_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
    logic       erro_q, erro_d;
`endif

    always_comb begin
        cont_d = cont_q;
        endr_d = endr_q;
        idx_d  = idx_q;
        dado_d = dado_q;
`ifdef CARREGADOR_CHECKSUM_EN
        xor_d  = xor_q;
        erro_d = erro_q;
`endif
        if (ocioso_ou_fim && inicio) begin
            cont_d = qtd_sat;
            endr_d = '0;
            idx_d  = 2'd0;
`ifdef CARREGADOR_CHECKSUM_EN
            xor_d  = 8'd0;
            erro_d = 1'b0;
`endif
        end else if (estado_q == RECEBE && aceita) begin
            dado_d[{idx_q, 3'b000} +: 8] = byte_in;
            idx_d = idx_q + 2'd1;
`ifdef CARREGADOR_CHECKSUM_EN
            xor_d = xor_q ^ byte_in;
`endif
        end else if (estado_q == ESCREVE) begin
            endr_d = endr_q + (ENDR_W+1)'(1);
            cont_d = cont_q - 6'd1;
            idx_d  = 2'd0;
        end
`ifdef CARREGADOR_CHECKSUM_EN
        else if (estado_q == CHECA && aceita) begin
            erro_d = (byte_in != xor_q);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cont_q       <= '0;
            endr_q       <= '0;
            idx_q        <= '0;
            dado_q       <= '0;
            carregando_q <= 1'b0;
            concluido_q  <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            cont_q       <= cont_d;
            endr_q       <= endr_d;
            idx_q        <= idx_d;
            dado_q       <= dado_d;
            carregando_q <= carregando_d;
            concluido_q  <= concluido_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

`ifdef CARREGADOR_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xor_q  <= 8'd0;
            erro_q <= 1'b0;
        end else begin
            xor_q  <= xor_d;
            erro_q <= erro_d;
        end
    end
    assign erro = erro_q;
`else
    assign erro = 1'b0;
`endif

    assign instr_endr = endr_q[ENDR_W-1:0];
    assign instr_dado = dado_q;
    assign carregando = carregando_q;
    assign concluido  = concluido_q;
    assign cpu_reset  = cpu_reset_q;

endmodule

// File: tb/tb_carregador_programa.sv
// Bench for carregador_programa: directed loads plus random traffic against a byte/word-level reference model.
module tb_carregador_programa;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inicio = 1'b0;
    logic [5:0]  qtd_palavras = 6'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valido = 1'b0;
    logic        pronto, instr_we, carregando, concluido, cpu_reset, erro;
    logic [4:0]  instr_endr;
    logic [31:0] instr_dado;

`ifdef CARREGADOR_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    carregador_programa #(.NUM_MAX(32), .ENDR_W(5)) dut (
        .clk(clk), .reset(rst), .inicio(inicio), .qtd_palavras(qtd_palavras),
        .byte_in(byte_in), .byte_valido(byte_valido), .pronto(pronto),
        .instr_we(instr_we), .instr_endr(instr_endr), .instr_dado(instr_dado),
        .carregando(carregando), .concluido(concluido), .cpu_reset(cpu_reset), .erro(erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: a load is a count of words, each built from 4 accepted bytes, then one write cycle.
    bit          m_active = 1'b0, m_tw = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int          m_nbuf = 0, m_left = 0, m_addr = 0;
    logic [7:0]  m_xor = 8'd0;
    logic [31:0] m_word = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0; m_tw <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_nbuf <= 0; m_left <= 0; m_addr <= 0; m_xor <= 8'd0; m_word <= 32'd0;
        end else if (!m_active && inicio) begin
            int sat;
            sat = (int'(qtd_palavras) > 32) ? 32 : int'(qtd_palavras);
            m_left <= sat; m_addr <= 0; m_nbuf <= 0; m_xor <= 8'd0; m_err <= 1'b0;
            m_done <= 1'b0; m_tw <= 1'b0;
            if (sat == 0) begin
                if (CHK) begin m_active <= 1'b1; m_tw <= 1'b1; end
                else m_done <= 1'b1;
            end else m_active <= 1'b1;
        end else if (m_active && !m_tw && m_nbuf == 4) begin
            m_addr <= m_addr + 1; m_left <= m_left - 1; m_nbuf <= 0;
            if (m_left == 1) begin
                if (CHK) m_tw <= 1'b1;
                else begin m_active <= 1'b0; m_done <= 1'b1; end
            end
        end else if (m_active && byte_valido) begin
            if (m_tw) begin
                m_err <= (byte_in != m_xor); m_active <= 1'b0; m_tw <= 1'b0; m_done <= 1'b1;
            end else begin
                m_word[8*m_nbuf +: 8] <= byte_in;
                m_nbuf <= m_nbuf + 1;
                m_xor  <= m_xor ^ byte_in;
            end
        end
    end

    logic exp_pronto, exp_we;
    assign exp_pronto = m_active && (m_tw || m_nbuf < 4);
    assign exp_we     = m_active && !m_tw && m_nbuf == 4;

    logic [4:0]  wlog_a[$];
    logic [31:0] wlog_d[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("pronto", pronto, exp_pronto);
            chk("instr_we", instr_we, exp_we);
            chk("carregando", carregando, m_active);
            chk("concluido", concluido, m_done);
            chk("cpu_reset", cpu_reset, !m_done);
            chk("erro", erro, m_err);
            if (exp_we) begin
                chk("instr_endr", instr_endr, m_addr[4:0]);
                chk("instr_dado", instr_dado, m_word);
            end
            if (instr_we) begin
                wlog_a.push_back(instr_endr);
                wlog_d.push_back(instr_dado);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start(input logic [5:0] q);
        wlog_a.delete(); wlog_d.delete();
        inicio = 1'b1; qtd_palavras = q;
        tick();
        inicio = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input string nm);
        bit ok = 1'b0;
        repeat (gap) tick();
        byte_in = b; byte_valido = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pronto) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        tick();
        byte_valido = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: byte %h never accepted, pronto stayed 0, expected 1", nm, b);
        end
    endtask

    task automatic trailer(input logic [7:0] b);
        if (CHK) send(b, 0, "trailer");
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (concluido) begin ok = 1'b1; break; end
        end
        tick();
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: concluido=0 after %0d cycles, expected 1", nm, budget);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pronto", pronto, 0);
        chk("rst_we", instr_we, 0);
        chk("rst_endr", instr_endr, 0);
        chk("rst_dado", instr_dado, 0);
        chk("rst_carregando", carregando, 0);
        chk("rst_concluido", concluido, 0);
        chk("rst_erro", erro, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        tick();

        // Single word, back-to-back
        start(6'd1);
        send(8'h83, 0, "w1b0"); send(8'h20, 0, "w1b1");
        send(8'h00, 0, "w1b2"); send(8'h00, 0, "w1b3");
        @(negedge clk);
        chk("single_we", instr_we, 1);
        chk("single_endr", instr_endr, 0);
        chk("single_dado", instr_dado, 32'h0000_2083);
`ifndef CARREGADOR_CHECKSUM_EN
        @(negedge clk);
        chk("single_concluido", concluido, 1);
        chk("single_cpu_reset", cpu_reset, 0);
`endif
        tick();
        trailer(8'h83 ^ 8'h20);
        wait_done(20, "single_done");
        chk("single_nwr", wlog_a.size(), 1);

        // Stalled stream, 3 words
        start(6'd3);
        for (int i = 0; i < 12; i++) send(8'h10 + 8'(i), 1, "stall");
        trailer(8'h10 ^ 8'h11 ^ 8'h12 ^ 8'h13 ^ 8'h14 ^ 8'h15 ^ 8'h16 ^ 8'h17 ^
                8'h18 ^ 8'h19 ^ 8'h1a ^ 8'h1b);
        wait_done(20, "stall_done");
        chk("stall_nwr", wlog_a.size(), 3);
        if (wlog_a.size() == 3) begin
            chk("stall_a0", wlog_a[0], 0); chk("stall_d0", wlog_d[0], 32'h1312_1110);
            chk("stall_a1", wlog_a[1], 1); chk("stall_d1", wlog_d[1], 32'h1716_1514);
            chk("stall_a2", wlog_a[2], 2); chk("stall_d2", wlog_d[2], 32'h1b1a_1918);
        end
        chk("stall_erro", erro, 0);

        // Oversized count saturates at 32 words
        start(6'd40);
        for (int i = 0; i < 128; i++) send(8'(i), 0, "full");
        trailer(8'h00);
        wait_done(20, "full_done");
        chk("full_nwr", wlog_a.size(), 32);
        if (wlog_a.size() == 32) begin
            chk("full_a0", wlog_a[0], 0);  chk("full_d0", wlog_d[0], 32'h0302_0100);
            chk("full_a31", wlog_a[31], 31); chk("full_d31", wlog_d[31], 32'h7f7e_7d7c);
        end

        // Empty load
        start(6'd0);
`ifndef CARREGADOR_CHECKSUM_EN
        @(negedge clk);
        chk("empty_concluido", concluido, 1);
        tick();
`endif
        trailer(8'h00);
        wait_done(5, "empty_done");
        repeat (3) tick();
        chk("empty_nwr", wlog_a.size(), 0);

        // Abort mid-load after 2 bytes of word 1
        start(6'd2);
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), 0, "abort");
        rst = 1'b1;
        @(negedge clk);
        chk("abort_pronto", pronto, 0);
        chk("abort_we", instr_we, 0);
        chk("abort_carregando", carregando, 0);
        chk("abort_cpu_reset", cpu_reset, 1);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("abort_nwr", wlog_a.size(), 1);
        start(6'd1);
        send(8'h01, 0, "reload"); send(8'h02, 0, "reload");
        send(8'h03, 0, "reload"); send(8'h04, 0, "reload");
        trailer(8'h04);
        wait_done(20, "reload_done");
        chk("reload_nwr", wlog_a.size(), 1);
        if (wlog_a.size() == 1) begin
            chk("reload_a0", wlog_a[0], 0);
            chk("reload_d0", wlog_d[0], 32'h0403_0201);
        end

`ifdef CARREGADOR_CHECKSUM_EN
        start(6'd1);
        send(8'h13, 0, "ck"); send(8'h00, 0, "ck"); send(8'h00, 0, "ck"); send(8'h00, 0, "ck");
        send(8'h13, 0, "ck_tr");
        wait_done(10, "ck_good_done");
        chk("ck_good_erro", erro, 0);
        chk("ck_good_cpu_reset", cpu_reset, 0);
        start(6'd1);
        send(8'h13, 0, "ck"); send(8'h00, 0, "ck"); send(8'h00, 0, "ck"); send(8'h00, 0, "ck");
        send(8'h12, 0, "ck_tr");
        wait_done(10, "ck_bad_done");
        chk("ck_bad_erro", erro, 1);
        chk("ck_bad_concluido", concluido, 1);
        chk("ck_bad_cpu_reset", cpu_reset, 0);
`endif

        // Random traffic: all inputs randomised, occasional start and reset
        for (int c = 0; c < 4000; c++) begin
            byte_valido  = ($urandom_range(0, 2) != 0);
            byte_in      = 8'($urandom);
            inicio       = ($urandom_range(0, 30) == 0);
            qtd_palavras = 6'($urandom_range(0, 40));
            rst          = ($urandom_range(0, 500) == 0);
            tick();
        end
        rst = 1'b0; inicio = 1'b0; byte_valido = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Program loader that fills the instruction memory before the processor runs. It accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes little-endian into a 32-bit instruction word. It writes that word into the instruction memory write port at consecutive word addresses, and holds the processor core (PC, instruction register) in reset until the load finishes. It is the writer side of the instruction memory that the program counter reads.

## Interface
Parameters:
- `NUM_MAX`, default 32: maximum words per load; equals instruction memory depth.
- `ENDR_W`, default 5: word-address width; matches the instruction memory `endr` width.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `reset`, input, 1: asynchronous, active-high.
- `inicio`, input, 1: start pulse; sampled only in OCIOSO or CONCLUIDO.
- `qtd_palavras`, input, 6: number of words to load, sampled with `inicio`. 0 means an empty load; values above `NUM_MAX` saturate to `NUM_MAX`.
- `byte_in`, input, 8: data byte.
- `byte_valido`, input, 1: `byte_in` is valid.
- `pronto`, output, 1: loader accepts a byte this cycle.
- `instr_we`, output, 1: instruction memory write enable.
- `instr_endr`, output, ENDR_W: word address of the write.
- `instr_dado`, output, 32: instruction word being written.
- `carregando`, output, 1: a load is in progress.
- `concluido`, output, 1: last load completed; held until the next `inicio` or `reset`.
- `cpu_reset`, output, 1: core hold; high in every state except CONCLUIDO.
- `erro`, output, 1: checksum mismatch (see Configuration).

## Operation
- FSM states: OCIOSO, RECEBE, ESCREVE, CHECA (only with the macro), CONCLUIDO.
- OCIOSO or CONCLUIDO, with `inicio`=1:
  - Load the word counter with the saturated `qtd_palavras`.
  - Clear the address, the byte index and `erro`.
  - Go to RECEBE. If the count is 0, go straight to CONCLUIDO (or CHECA when checksum is enabled).
- RECEBE:
  - `pronto`=1.
  - A byte is accepted when `byte_valido && pronto`.
  - Byte index k (0..3) goes to bits [8k+7:8k].
  - When the 4th byte is accepted, go to ESCREVE.
- ESCREVE, one cycle:
  - `instr_we`=1 and `pronto`=0.
  - Then increment the address, decrement the counter and reset the byte index.
  - Counter reaches 0: go to CHECA or CONCLUIDO. Otherwise return to RECEBE.
- `byte_valido` outside RECEBE and CHECA is ignored and the byte is dropped.
- `inicio` during RECEBE, ESCREVE or CHECA is ignored.
- The address never wraps, because the counter is saturated at `NUM_MAX`. After a full 32-word load the internal address is 32; only `instr_endr`[ENDR_W-1:0] is driven, and no write occurs at that value.
- Asserting `reset` mid-load:
  - Clears everything immediately and drops the partial word.
  - Memory words already written are left intact.
  - The FSM returns to OCIOSO with `cpu_reset`=1.

## Timing
- Reset values:
  - State OCIOSO.
  - `pronto`=0, `instr_we`=0, `instr_endr`=0, `instr_dado`=0.
  - `carregando`=0, `concluido`=0, `erro`=0, `cpu_reset`=1.
- All outputs are registered, except that `pronto` and `instr_we` are decoded from the state register.
- Write latency: `instr_we` is high in the cycle after the 4th byte's accepting edge.
- `instr_endr` and `instr_dado` are stable throughout that cycle. Memory captures them on the next rising edge.
- Minimum of 5 cycles per word (4 bytes plus 1 write). Back-to-back bytes are accepted every cycle in RECEBE.
- `carregando`=1 in RECEBE, ESCREVE and CHECA.
- `concluido` and the release of `cpu_reset` take effect on the same edge that enters CONCLUIDO.
- `inicio` in CONCLUIDO:
  - Clears `concluido` and raises `cpu_reset` on the next edge.
  - Re-enters RECEBE one cycle after it is sampled.

## Configuration
- Macro `CARREGADOR_CHECKSUM_EN`.
- Defined:
  - The loader keeps a running XOR of all data bytes.
  - After the last write, the FSM enters CHECA with `pronto`=1 and accepts one trailer byte.
  - Trailer not equal to the running XOR: `erro`=1 on the transition to CONCLUIDO.
  - `cpu_reset` releases regardless of `erro`; the team decides separately whether to use `erro` to gate the core.
- Undefined:
  - No CHECA state, no XOR register, and no trailer byte.
  - `erro` is tied to 0.

## Test plan
- Reset check: assert `reset` for 3 cycles, then release → all outputs at reset values, `cpu_reset`=1, `pronto`=0.
- Single word: `inicio`, `qtd_palavras`=1, bytes 0x83,0x20,0x00,0x00 back-to-back → one `instr_we` pulse, `instr_endr`=0, `instr_dado`=0x00002083. `concluido`=1 and `cpu_reset`=0 follow one cycle later.
- Stalled stream, 3 words: `byte_valido` toggles every other cycle → writes at addresses 0,1,2 with correct words; `pronto`=0 during each ESCREVE cycle; no byte is lost.
- Full memory: `qtd_palavras`=40, stream 128 bytes → exactly 32 writes (addresses 0..31), then `concluido`. `qtd_palavras`=0 → `concluido` 1 cycle after `inicio`, no writes.
- Abort mid-load: `reset` asserted after 2 bytes of word 1 → no further `instr_we`, state OCIOSO, `cpu_reset`=1. A new `inicio` then loads from address 0.
- Checksum, with `CARREGADOR_CHECKSUM_EN`: 1 word 0x13,0x00,0x00,0x00 with trailer 0x13 gives `erro`=0; trailer 0x12 gives `erro`=1; `concluido`=1 in both cases.
